// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_pkg;

    localparam int RISCV_WORD = 32;

    // addi x0,x0,0 -- the reset and fill value of the program store
    localparam logic [RISCV_WORD-1:0] NOP_WORD_DFLT = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/prog_store.sv
// Program store: DEPTH x 32 flop array, one synchronous write port and one combinational read port.
// Latency: write takes effect at the clock edge; read is combinational (old word visible during a same-cycle write).
// Backpressure: none, writes are always accepted.
// Ports: clk/reset (async active-low, fills every word with INIT), we/waddr/wdata write port, raddr/rdata read port.
module prog_store
    import imem_pkg::*;
#(
    parameter int                    DEPTH = 16,
    parameter logic [RISCV_WORD-1:0] INIT  = NOP_WORD_DFLT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [RISCV_WORD-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [RISCV_WORD-1:0]    rdata
);

    logic [RISCV_WORD-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INIT;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_prog_responder.sv
// Instruction-memory responder: address-driven fetch from a loadable program store, one request in flight.
// Latency: LATENCY cycles from request accept to resp_valid (1..4); LATENCY==1 streams one response per cycle.
// Backpressure: response held stable until resp_ready; req_ready only in IDLE, or in RESP while resp_ready is high.
// Ports: clk/reset (async active-low), prog_* store write port, req_* fetch request, resp_* response, busy = not IDLE.
module imem_prog_responder
    import imem_pkg::*;
#(
    parameter int                    DEPTH    = 16,
    parameter int                    LATENCY  = 1,
    parameter logic [RISCV_WORD-1:0] NOP_WORD = NOP_WORD_DFLT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [RISCV_WORD-1:0]    prog_wdata,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [RISCV_WORD-1:0]    resp_data,
    output logic [31:0]              resp_addr,
    output logic                     resp_err,
    output logic                     busy
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [1:0] CNT_LOAD = 2'(LATENCY - 1);

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [RISCV_WORD-1:0] data_q;
    logic [31:0]           addr_q;
    logic                  err_q;

    logic                  accept;
    logic                  misaligned;
    logic [AW-1:0]         rd_idx;
    logic [RISCV_WORD-1:0] rd_word;

    // Higher address bits are dropped, so fetches wrap modulo DEPTH*4 bytes.
    assign rd_idx     = req_addr[2 +: AW];
    assign misaligned = (req_addr[1:0] != 2'b00);

    prog_store #(
        .DEPTH (DEPTH),
        .INIT  (NOP_WORD)
    ) u_store (
        .clk   (clk),
        .reset (reset),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (rd_idx),
        .rdata (rd_word)
    );

    // Gated by reset so nothing looks acceptable while reset is held.
    assign req_ready  = reset && ((state_q == IDLE) || ((state_q == RESP) && resp_ready));
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_data  = data_q;
    assign resp_addr  = addr_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    if (accept) begin
                        cnt_d   = CNT_LOAD;
                        state_d = (LATENCY == 1) ? RESP : WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Captured at accept from the pre-edge store contents, so a same-cycle
    // write to the fetched index returns the old word and later writes never
    // disturb a response already in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= NOP_WORD;
            addr_q <= 32'd0;
            err_q  <= 1'b0;
        end else if (accept) begin
            data_q <= misaligned ? NOP_WORD : rd_word;
            addr_q <= req_addr;
            err_q  <= misaligned;
        end
    end

endmodule

// File: tb/tb_imem_prog_responder.sv
module tb_imem_prog_responder;

    logic        clk;
    logic        reset;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [31:0] prog_wdata;
    logic [31:0] req_addr;
    logic        resp_ready;

    logic        req_valid1, req_valid3, req_valid4;
    logic        r1_rdy, r1_vld, r1_err, r1_busy;
    logic        r3_rdy, r3_vld, r3_err, r3_busy;
    logic        r4_rdy, r4_vld, r4_err, r4_busy;
    logic [31:0] r1_data, r1_addr, r3_data, r3_addr, r4_data, r4_addr;

    int checks = 0;
    int errors = 0;

    imem_prog_responder #(.DEPTH(16), .LATENCY(1), .NOP_WORD(32'h0000_0013)) u1 (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .req_valid(req_valid1), .req_ready(r1_rdy), .req_addr(req_addr),
        .resp_valid(r1_vld), .resp_ready(resp_ready), .resp_data(r1_data), .resp_addr(r1_addr),
        .resp_err(r1_err), .busy(r1_busy)
    );

    imem_prog_responder #(.DEPTH(16), .LATENCY(3), .NOP_WORD(32'h0000_0013)) u3 (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .req_valid(req_valid3), .req_ready(r3_rdy), .req_addr(req_addr),
        .resp_valid(r3_vld), .resp_ready(resp_ready), .resp_data(r3_data), .resp_addr(r3_addr),
        .resp_err(r3_err), .busy(r3_busy)
    );

    imem_prog_responder #(.DEPTH(16), .LATENCY(4), .NOP_WORD(32'h0000_0013)) u4 (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .req_valid(req_valid4), .req_ready(r4_rdy), .req_addr(req_addr),
        .resp_valid(r4_vld), .resp_ready(resp_ready), .resp_data(r4_data), .resp_addr(r4_addr),
        .resp_err(r4_err), .busy(r4_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [3:0] idx, input logic [31:0] val);
        prog_we    = 1'b1;
        prog_addr  = idx;
        prog_wdata = val;
        tick();
        prog_we    = 1'b0;
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        prog_we    = 1'b0;
        prog_addr  = 4'd0;
        prog_wdata = 32'd0;
        req_addr   = 32'd0;
        resp_ready = 1'b0;
        req_valid1 = 1'b0;
        req_valid3 = 1'b0;
        req_valid4 = 1'b0;

        // ---- reset state ----
        #2 reset = 1'b0;
        #1;
        chk("rst_req_ready_low", {31'd0, r1_rdy}, 32'd0);
        chk("rst_resp_valid", {31'd0, r1_vld}, 32'd0);
        chk("rst_resp_data", r1_data, 32'h0000_0013);
        chk("rst_resp_addr", r1_addr, 32'd0);
        chk("rst_resp_err", {31'd0, r1_err}, 32'd0);
        chk("rst_busy", {31'd0, r1_busy}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("post_rst_req_ready", {31'd0, r1_rdy}, 32'd1);

        // ---- program a few words ----
        write_word(4'd0, 32'h01AE_85B3);
        write_word(4'd1, 32'h1111_1111);
        write_word(4'd2, 32'h2222_2222);

        // ---- LATENCY=1 basic fetch ----
        resp_ready = 1'b1;
        req_addr   = 32'h0;
        req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        chk("l1_valid", {31'd0, r1_vld}, 32'd1);
        chk("l1_data", r1_data, 32'h01AE_85B3);
        chk("l1_addr", r1_addr, 32'h0);
        chk("l1_err", {31'd0, r1_err}, 32'd0);
        tick();
        chk("l1_idle_valid", {31'd0, r1_vld}, 32'd0);
        chk("l1_idle_busy", {31'd0, r1_busy}, 32'd0);

        // ---- LATENCY=3 with held response ----
        resp_ready = 1'b0;
        req_addr   = 32'h8;
        req_valid3 = 1'b1;
        #1;
        chk("l3_idle_ready", {31'd0, r3_rdy}, 32'd1);
        tick();
        req_valid3 = 1'b0;
        chk("l3_n0_valid", {31'd0, r3_vld}, 32'd0);
        chk("l3_n0_busy", {31'd0, r3_busy}, 32'd1);
        chk("l3_n0_ready", {31'd0, r3_rdy}, 32'd0);
        tick();
        chk("l3_n1_valid", {31'd0, r3_vld}, 32'd0);
        tick();
        chk("l3_n2_valid", {31'd0, r3_vld}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("l3_hold_valid", {31'd0, r3_vld}, 32'd1);
            chk("l3_hold_data", r3_data, 32'h2222_2222);
            chk("l3_hold_addr", r3_addr, 32'h8);
            chk("l3_hold_err", {31'd0, r3_err}, 32'd0);
            chk("l3_hold_ready", {31'd0, r3_rdy}, 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("l3_release_ready", {31'd0, r3_rdy}, 32'd1);
        tick();
        chk("l3_released_valid", {31'd0, r3_vld}, 32'd0);
        chk("l3_released_busy", {31'd0, r3_busy}, 32'd0);

        // ---- wrap and misalignment (back-to-back, LATENCY=1) ----
        req_addr   = 32'h44;
        req_valid1 = 1'b1;
        tick();
        chk("wrap_data", r1_data, 32'h1111_1111);
        chk("wrap_addr", r1_addr, 32'h44);
        chk("wrap_err", {31'd0, r1_err}, 32'd0);
        req_addr = 32'h6;
        tick();
        chk("mis_valid", {31'd0, r1_vld}, 32'd1);
        chk("mis_err", {31'd0, r1_err}, 32'd1);
        chk("mis_data", r1_data, 32'h0000_0013);
        chk("mis_addr", r1_addr, 32'h6);
        req_valid1 = 1'b0;
        tick();

        // ---- same-cycle write and fetch of index 5 ----
        prog_we    = 1'b1;
        prog_addr  = 4'd5;
        prog_wdata = 32'hDEAD_BEEF;
        req_addr   = 32'h14;
        req_valid1 = 1'b1;
        tick();
        prog_we = 1'b0;
        chk("rbw_old_word", r1_data, 32'h0000_0013);
        tick();
        chk("rbw_new_word", r1_data, 32'hDEAD_BEEF);
        req_valid1 = 1'b0;
        tick();

        // ---- LATENCY=1 streaming of all 16 words ----
        for (int i = 0; i < 16; i++) begin
            write_word(4'(i), 32'hA000_0000 + 32'(i));
        end
        req_valid1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req_addr = 32'(i * 4);
            tick();
            chk("stream_valid", {31'd0, r1_vld}, 32'd1);
            chk("stream_data", r1_data, 32'hA000_0000 + 32'(i));
            chk("stream_addr", r1_addr, 32'(i * 4));
        end
        req_valid1 = 1'b0;
        tick();
        chk("stream_end_valid", {31'd0, r1_vld}, 32'd0);

        // ---- reset during WAIT (LATENCY=4) ----
        req_addr   = 32'h0;
        req_valid4 = 1'b1;
        tick();
        req_valid4 = 1'b0;
        chk("l4_wait_busy", {31'd0, r4_busy}, 32'd1);
        chk("l4_wait_valid", {31'd0, r4_vld}, 32'd0);
        tick();
        chk("l4_wait2_valid", {31'd0, r4_vld}, 32'd0);
        reset = 1'b0;
        #1;
        chk("l4_rst_busy", {31'd0, r4_busy}, 32'd0);
        chk("l4_rst_ready", {31'd0, r4_rdy}, 32'd0);
        chk("l4_rst_valid", {31'd0, r4_vld}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("l4_no_valid", {31'd0, r4_vld}, 32'd0);
        end
        req_addr   = 32'h0;
        req_valid4 = 1'b1;
        tick();
        req_valid4 = 1'b0;
        n = 0;
        while (!r4_vld && n < 8) begin
            tick();
            n++;
        end
        chk("l4_latency_edges", 32'(n), 32'd3);
        chk("l4_after_rst_data", r4_data, 32'h0000_0013);
        chk("l4_after_rst_err", {31'd0, r4_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
